// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
//   Shared types and constants for the load/store sequencer:
//   - state_t     : FSM state encoding
//   - SIZE_BYTE / SIZE_WORD : access-size encoding of req_byte
//   - RST_*       : reset values for registered data and state
//   - extend_byte : sign/zero extension of a selected load byte
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

  // IDLE   : waiting for a request, req_ready high
  // A0/W0  : first word access (read) and its merge write
  // A1/W1  : second word access of a split misaligned word, and its write
  // DONE   : one-cycle completion pulse
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A0   = 3'd1,
    ST_W0   = 3'd2,
    ST_A1   = 3'd3,
    ST_W1   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  localparam logic [15:0] RST_DATA  = 16'h0000;
  localparam state_t      RST_STATE = ST_IDLE;

  // Widen a byte to 16 bits, replicating bit 7 only for signed loads.
  function automatic logic [15:0] extend_byte(input logic [7:0] b,
                                              input logic       is_signed);
    return {{8{is_signed & b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
//   Bundles the execute-stage request/response handshake and the word-wide
//   data-memory port of the load/store sequencer.
//   Request : req_valid, req_ready, req_we, req_byte, req_signed,
//             req_addr, req_wdata
//   Response: rsp_valid, rsp_data
//   Memory  : addrm, wmdata, re, we, mem_alu (outputs of the unit),
//             rwdata (combinational read data into the unit)
//   Modports:
//     slave  - the sequencer itself
//     master - the surrounding execute stage plus memory
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int ADDR_W = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_byte;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;

  logic              rsp_valid;
  logic [15:0]       rsp_data;

  logic [ADDR_W-1:0] addrm;
  logic [15:0]       wmdata;
  logic              re;
  logic              we;
  logic              mem_alu;
  logic [15:0]       rwdata;

  modport slave (
    input  req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_data,
    output addrm, wmdata, re, we, mem_alu,
    input  rwdata
  );

  modport master (
    output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_data,
    input  addrm, wmdata, re, we, mem_alu,
    output rwdata
  );

endinterface

// File: rtl/mem_access_unit_byte_lane_merge.sv
// ---------------------------------------------------------------------------
// byte_lane_merge
//   Purely combinational byte-lane helper for the load/store sequencer.
//   Load side : picks the high or low byte of ld_word and extends it to
//               16 bits (sign or zero) into ld_data.
//   Store side: replaces the high or low byte of st_word with st_byte,
//               giving the word to write back in st_data.
//   Ports:
//     ld_word, ld_hi, ld_signed -> ld_data
//     st_word, st_hi, st_byte   -> st_data
// ---------------------------------------------------------------------------
module byte_lane_merge
  import mem_access_unit_pkg::*;
(
  input  logic [15:0] ld_word,
  input  logic        ld_hi,
  input  logic        ld_signed,
  output logic [15:0] ld_data,
  input  logic [15:0] st_word,
  input  logic        st_hi,
  input  logic [7:0]  st_byte,
  output logic [15:0] st_data
);

  logic [7:0] ld_lane;

  always_comb begin
    ld_lane = ld_hi ? ld_word[15:8] : ld_word[7:0];
    ld_data = extend_byte(ld_lane, ld_signed);
  end

  always_comb begin
    if (st_hi) begin
      st_data = {st_byte, st_word[7:0]};
    end else begin
      st_data = {st_word[15:8], st_byte};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store sequencer in front of a byte-organised 16-bit data memory.
//   Takes one request at a time, always presents even word addresses to the
//   memory, performs byte stores by read-modify-write and splits misaligned
//   word accesses into two word accesses.
//   Parameters:
//     ADDR_W      - address width, all address arithmetic wraps
//     MISALIGN_EN - 1: split misaligned words, 0: treat them as aligned
//   Ports:
//     clock   - rising-edge clock
//     reset_n - asynchronous active-low reset
//     bus     - request/response handshake and memory port (slave side)
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  mem_access_unit_if.slave bus
);

  state_t state;
  state_t state_next;

  logic              lat_we;
  logic              lat_byte;
  logic              lat_signed;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_wdata;

  logic [15:0]       cap_word;
  logic              cap_en;
  logic [15:0]       rsp_data_q;
  logic [15:0]       rsp_next;

  logic              accept;
  logic              misaligned;
  logic              aligned_word_store;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] next_addr;

  logic              req_ready;
  logic [ADDR_W-1:0] addrm;
  logic [15:0]       wmdata;
  logic              re;
  logic              we;

  logic [15:0]       ld_data;
  logic              st_hi;
  logic [7:0]        st_byte;
  logic [15:0]       st_data;

  assign accept     = (state == ST_IDLE) && bus.req_valid;
  assign misaligned = MISALIGN_EN && (lat_byte == SIZE_WORD) && lat_addr[0];
  assign aligned_word_store = lat_we && (lat_byte == SIZE_WORD) && !misaligned;
  assign base_addr  = {lat_addr[ADDR_W-1:1], 1'b0};
  assign next_addr  = base_addr + ADDR_W'(2);

  // In W1 the low byte of the second word receives the upper store byte.
  // Elsewhere the replaced lane is the addressed byte for byte stores and
  // the high byte of the first word for split word stores.
  assign st_hi   = (state == ST_W1) ? 1'b0 :
                   ((lat_byte == SIZE_BYTE) ? lat_addr[0] : 1'b1);
  assign st_byte = (state == ST_W1) ? lat_wdata[15:8] : lat_wdata[7:0];

  byte_lane_merge u_merge (
    .ld_word   (bus.rwdata),
    .ld_hi     (lat_addr[0]),
    .ld_signed (lat_signed),
    .ld_data   (ld_data),
    .st_word   (cap_word),
    .st_hi     (st_hi),
    .st_byte   (st_byte),
    .st_data   (st_data)
  );

  // State register. Reset is asynchronous so that the decoded write enable
  // drops immediately and an in-flight store is abandoned.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RST_STATE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch: the unit works only from these copies, so the execute
  // stage may change its request lines freely once accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_we     <= 1'b0;
      lat_byte   <= SIZE_WORD;
      lat_signed <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= RST_DATA;
    end else if (accept) begin
      lat_we     <= bus.req_we;
      lat_byte   <= bus.req_byte;
      lat_signed <= bus.req_signed;
      lat_addr   <= bus.req_addr;
      lat_wdata  <= bus.req_wdata;
    end
  end

  // Read-data capture and registered response. A single capture register
  // is enough: a split load consumes the first word while the second is
  // still on rwdata, and a split store has finished with the first word
  // before the second one is read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_word   <= RST_DATA;
      rsp_data_q <= RST_DATA;
    end else begin
      if (cap_en) begin
        cap_word <= bus.rwdata;
      end
      rsp_data_q <= rsp_next;
    end
  end

  // Next-state and memory-port decode. rsp_next is non-zero only on the
  // edge entering DONE, which keeps rsp_data at zero everywhere else.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    addrm      = '0;
    wmdata     = RST_DATA;
    re         = 1'b0;
    we         = 1'b0;
    cap_en     = 1'b0;
    rsp_next   = RST_DATA;

    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          state_next = ST_A0;
        end
      end

      ST_A0: begin
        addrm = base_addr;
        if (aligned_word_store) begin
          we         = 1'b1;
          wmdata     = lat_wdata;
          state_next = ST_DONE;
        end else begin
          re     = 1'b1;
          cap_en = 1'b1;
          if (lat_we) begin
            state_next = ST_W0;
          end else if (misaligned) begin
            state_next = ST_A1;
          end else begin
            state_next = ST_DONE;
            rsp_next   = (lat_byte == SIZE_BYTE) ? ld_data : bus.rwdata;
          end
        end
      end

      ST_W0: begin
        addrm      = base_addr;
        we         = 1'b1;
        wmdata     = st_data;
        state_next = misaligned ? ST_A1 : ST_DONE;
      end

      ST_A1: begin
        addrm  = next_addr;
        re     = 1'b1;
        cap_en = 1'b1;
        if (lat_we) begin
          state_next = ST_W1;
        end else begin
          state_next = ST_DONE;
          rsp_next   = {bus.rwdata[7:0], cap_word[15:8]};
        end
      end

      ST_W1: begin
        addrm      = next_addr;
        we         = 1'b1;
        wmdata     = st_data;
        state_next = ST_DONE;
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state == ST_DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.addrm     = addrm;
  assign bus.wmdata    = wmdata;
  assign bus.re        = re;
  assign bus.we        = we;
  assign bus.mem_alu   = 1'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a byte-array memory model.
//   Expected reads, writes and responses are queued as each request is
//   issued and consumed by negedge monitors as the unit produces them.
//   A second instance with MISALIGN_EN=0 covers the aligned fallback.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  logic clock;
  logic reset_n;

  mem_access_unit_if #(.ADDR_W(16)) bus ();
  mem_access_unit_if #(.ADDR_W(16)) bus0 ();

  mem_access_unit #(.ADDR_W(16), .MISALIGN_EN(1'b1)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  mem_access_unit #(.ADDR_W(16), .MISALIGN_EN(1'b0)) u_dut_noalign (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  typedef struct {
    logic [15:0] data;
    int          lat;
    int          acc;
  } rsp_exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_exp_t;

  logic [7:0]  mem [0:65535];
  rsp_exp_t    rsp_q [$];
  wr_exp_t     wr_q [$];
  logic [15:0] rd_q [$];

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cycle <= cycle + 1;

  // Memory model: combinational word read, byte pair written on the edge.
  assign bus.rwdata  = {mem[bus.addrm | 16'h0001], mem[bus.addrm & 16'hFFFE]};
  assign bus0.rwdata = {mem[bus0.addrm | 16'h0001], mem[bus0.addrm & 16'hFFFE]};

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h34;
    mem[16'h0101] = 8'h12;
    mem[16'h0102] = 8'h78;
    mem[16'h00FE] = 8'h11;
    mem[16'h00FF] = 8'h80;
    mem[16'hFFFE] = 8'h55;
    mem[16'hFFFF] = 8'h66;
    mem[16'h0000] = 8'h77;
    mem[16'h0001] = 8'h88;
    mem[16'h0400] = 8'h5A;
    mem[16'h0401] = 8'hA5;
    forever begin
      @(posedge clock);
      if (bus.we) begin
        mem[bus.addrm & 16'hFFFE] = bus.wmdata[7:0];
        mem[bus.addrm | 16'h0001] = bus.wmdata[15:8];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expectRead(input logic [15:0] addr);
    rd_q.push_back(addr);
  endtask

  task automatic expectWrite(input logic [15:0] addr, input logic [15:0] data);
    wr_exp_t w;
    w.addr = addr;
    w.data = data;
    wr_q.push_back(w);
  endtask

  task automatic applyStimulus(input logic we_i, input logic byte_i,
                               input logic signed_i, input logic [15:0] addr_i,
                               input logic [15:0] wdata_i, input bit expect_rsp,
                               input logic [15:0] exp_data, input int exp_lat);
    rsp_exp_t e;
    for (int i = 0; i < 40 && !bus.req_ready; i++) @(negedge clock);
    bus.req_we     = we_i;
    bus.req_byte   = byte_i;
    bus.req_signed = signed_i;
    bus.req_addr   = addr_i;
    bus.req_wdata  = wdata_i;
    bus.req_valid  = 1'b1;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    if (expect_rsp) begin
      e.data = exp_data;
      e.lat  = exp_lat;
      e.acc  = cycle;
      rsp_q.push_back(e);
    end
  endtask

  task automatic waitDone();
    int i = 0;
    while (rsp_q.size() != 0 && i < 40) begin
      @(negedge clock);
      i++;
    end
    checkOutput("rsp_timeout", 32'(rsp_q.size()), 32'd0);
    checkOutput("reads_left", 32'(rd_q.size()), 32'd0);
    checkOutput("writes_left", 32'(wr_q.size()), 32'd0);
    @(negedge clock);
  endtask

  // Response monitor: data and in-flight cycle count of each completion.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          rsp_exp_t e;
          e = rsp_q.pop_front();
          checkOutput("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          checkOutput("rsp_latency", 32'(cycle - e.acc + 1), 32'(e.lat));
        end
      end else begin
        checkOutput("rsp_data_idle", 32'(bus.rsp_data), 32'd0);
      end
    end
  end

  // Memory-port monitor: every read address and every write beat in order.
  always @(negedge clock) begin
    if (reset_n) begin
      checkOutput("addrm_even", 32'(bus.addrm[0]), 32'd0);
      checkOutput("mem_alu", 32'(bus.mem_alu), 32'd0);
      if (bus.we) begin
        if (wr_q.size() == 0) begin
          checkOutput("write_unexpected", 32'(bus.we), 32'd0);
        end else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          checkOutput("write_addr", 32'(bus.addrm), 32'(w.addr));
          checkOutput("write_data", 32'(bus.wmdata), 32'(w.data));
        end
      end else if (bus.re) begin
        if (rd_q.size() == 0) begin
          checkOutput("read_unexpected", 32'(bus.re), 32'd0);
        end else begin
          logic [15:0] a;
          a = rd_q.pop_front();
          checkOutput("read_addr", 32'(bus.addrm), 32'(a));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_byte    = 1'b0;
    bus.req_signed  = 1'b0;
    bus.req_addr    = 16'h0000;
    bus.req_wdata   = 16'h0000;
    bus0.req_valid  = 1'b0;
    bus0.req_we     = 1'b0;
    bus0.req_byte   = 1'b0;
    bus0.req_signed = 1'b0;
    bus0.req_addr   = 16'h0000;
    bus0.req_wdata  = 16'h0000;

    // Reset state
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    checkOutput("rst_we", 32'(bus.we), 32'd0);
    checkOutput("rst_re", 32'(bus.re), 32'd0);
    checkOutput("rst_addrm", 32'(bus.addrm), 32'd0);
    checkOutput("rst_wmdata", 32'(bus.wmdata), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] aligned word load 0x0100");
    expectRead(16'h0100);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'h1234, 2);
    waitDone();

    $display("[TB] misaligned word load 0x0101");
    expectRead(16'h0100);
    expectRead(16'h0102);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0101, 16'h0000, 1'b1, 16'h7812, 3);
    waitDone();

    $display("[TB] byte loads around 0x00FE");
    expectRead(16'h00FE);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h00FF, 16'h0000, 1'b1, 16'hFF80, 2);
    waitDone();
    expectRead(16'h00FE);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0080, 2);
    waitDone();
    expectRead(16'h00FE);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h00FE, 16'h0000, 1'b1, 16'h0011, 2);
    waitDone();

    $display("[TB] byte store 0xAB to 0x0101");
    expectRead(16'h0100);
    expectWrite(16'h0100, 16'hAB34);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0101, 16'h55AB, 1'b1, 16'h0000, 3);
    waitDone();
    expectRead(16'h0100);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'hAB34, 2);
    waitDone();

    $display("[TB] wrapping word store 0xBEEF at 0xFFFF");
    expectRead(16'hFFFE);
    expectWrite(16'hFFFE, 16'hEF55);
    expectRead(16'h0000);
    expectWrite(16'h0000, 16'h88BE);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hBEEF, 1'b1, 16'h0000, 5);
    waitDone();
    checkOutput("mem_fffe", 32'(mem[16'hFFFE]), 32'h55);
    checkOutput("mem_ffff", 32'(mem[16'hFFFF]), 32'hEF);
    checkOutput("mem_0000", 32'(mem[16'h0000]), 32'hBE);
    checkOutput("mem_0001", 32'(mem[16'h0001]), 32'h88);

    $display("[TB] aligned word store then load at 0x0200");
    expectWrite(16'h0200, 16'hCAFE);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0200, 16'hCAFE, 1'b1, 16'h0000, 2);
    waitDone();
    expectRead(16'h0200);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, 1'b1, 16'hCAFE, 2);
    waitDone();

    $display("[TB] request lines changed while busy");
    expectRead(16'h0100);
    expectRead(16'h0102);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0101, 16'h0000, 1'b1, 16'h78AB, 3);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_byte  = 1'b1;
    bus.req_addr  = 16'h0300;
    bus.req_wdata = 16'hDEAD;
    @(negedge clock);
    checkOutput("busy_ready_a0", 32'(bus.req_ready), 32'd0);
    @(negedge clock);
    checkOutput("busy_ready_a1", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    waitDone();
    checkOutput("mem_0300", 32'(mem[16'h0300]), 32'h00);

    $display("[TB] reset during byte-store write cycle");
    expectRead(16'h0400);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0400, 16'h00FF, 1'b0, 16'h0000, 0);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_we", 32'(bus.we), 32'd0);
    checkOutput("abort_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("abort_re", 32'(bus.re), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("abort_mem_0400", 32'(mem[16'h0400]), 32'h5A);
    checkOutput("abort_mem_0401", 32'(mem[16'h0401]), 32'hA5);
    checkOutput("abort_reads_left", 32'(rd_q.size()), 32'd0);
    expectRead(16'h0400);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0401, 16'h0000, 1'b1, 16'h00A5, 2);
    waitDone();

    $display("[TB] misaligned word load with splitting disabled");
    for (int i = 0; i < 40 && !bus0.req_ready; i++) @(negedge clock);
    bus0.req_addr  = 16'h0101;
    bus0.req_valid = 1'b1;
    @(posedge clock);
    #1 bus0.req_valid = 1'b0;
    @(negedge clock);
    checkOutput("noalign_addrm", 32'(bus0.addrm), 32'h0100);
    checkOutput("noalign_re", 32'(bus0.re), 32'd1);
    @(negedge clock);
    checkOutput("noalign_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    checkOutput("noalign_rsp_data", 32'(bus0.rsp_data), 32'hAB34);
    @(negedge clock);
    checkOutput("noalign_idle", 32'(bus0.req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer sitting directly upstream of the byte-organised 16-bit data memory.
- Accepts one load/store request at a time from the execute stage.
- Drives the memory's addrm/wmdata/re/we/mem_alu port with even (word) addresses only.
- Implements byte loads with sign/zero extension, byte stores by read-modify-write, and misaligned word accesses as two word accesses.
- Returns load data and a completion pulse to the execute stage.

Parameters:
ADDR_W, 16, address width; all address arithmetic wraps modulo 2^ADDR_W.
MISALIGN_EN, 1, 1 = split misaligned word accesses; 0 = clear addr[0] and treat as aligned.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE; request accepted on edge where valid&&ready.
req_we  input  1  1 = store, 0 = load.
req_byte  input  1  1 = byte access, 0 = word access.
req_signed  input  1  byte load: 1 = sign-extend, 0 = zero-extend.
req_addr  input  ADDR_W  byte address.
req_wdata  input  16  store data; byte store uses [7:0].
rsp_valid  output  1  one-cycle completion pulse (loads and stores).
rsp_data  output  16  load result, valid while rsp_valid; 0 for stores.
addrm  output  ADDR_W  memory address; bit 0 always 0.
wmdata  output  16  memory write data.
re  output  1  read strobe, high in read states.
we  output  1  memory write enable, high only in write states.
mem_alu  output  1  tied 0; the unit always consumes direct read data.
rwdata  input  16  combinational memory read data {mem[addrm+1], mem[addrm]}.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; req_ready=1; rsp_valid=0, rsp_data=0; we=0, re=0; addrm=0, wmdata=0; request latches cleared.
- Memory-side outputs decode combinationally from the state register and latched request, so reset drops we with no clock edge.
- Request latching: on acceptance, latch we/byte/signed/addr/wdata. Input changes after acceptance are ignored.
- States: IDLE, A0 (first access), W0 (first write), A1 (second access), W1 (second write), DONE.
- A0: addrm = {addr[15:1],0}, re=1.
  - Load: capture rwdata on the exit edge.
  - Aligned word store: we=1 with wmdata = wdata instead of reading.
- W0: we=1, addrm as A0, wmdata = captured word with one byte replaced.
  - Byte store: byte addr[0] replaced by wdata[7:0].
  - Misaligned word store: high byte replaced by wdata[7:0].
- A1: addrm = {addr[15:1],0}+2 (wraps 0xFFFE→0x0000), re=1, capture rwdata.
- W1: we=1 at the A1 address; low byte replaced by wdata[15:8].
- Transitions and in-flight cycles (acceptance edge to rsp_valid cycle, inclusive):
  - Aligned word load/store: A0→DONE, 2 cycles.
  - Byte load: A0→DONE, 2 cycles.
  - Byte store: A0→W0→DONE, 3 cycles.
  - Misaligned word load: A0→A1→DONE, 3 cycles.
  - Misaligned word store: A0→W0→A1→W1→DONE, 5 cycles.
  - DONE→IDLE unconditionally; there is no back-to-back acceptance from DONE.
- Load results:
  - Aligned word: captured word.
  - Misaligned word: {second[7:0], first[15:8]}.
  - Byte: select first[7:0] if addr[0]=0 else first[15:8], then extend per req_signed.
- rsp_data is registered and cleared to 0 in all states except DONE.
- Boundaries:
  - req_valid while not IDLE is ignored.
  - Address 0xFFFF misaligned word access touches 0xFFFE and 0x0000.
  - Reset mid-operation aborts; no further write occurs, and a write already committed on an earlier edge stays.
  - MISALIGN_EN=0: a misaligned word access behaves exactly as aligned at addr&~1.

Decomposition:
- Shared package: state encodings, access-size constants (SIZE_BYTE, SIZE_WORD), reset values.
- One combinational sub-module, byte_lane_merge:
  - Byte-select with sign/zero extension for loads.
  - Byte-replace for store merge.
- FSM and latches stay in mem_access_unit.

Test Plan:
- Preload bytes 0x0100=34,0x0101=12; word load 0x0100 → addrm 0x0100, rsp_data 0x1234, rsp_valid in cycle 2 after acceptance.
- Preload 0x0102=78; word load 0x0101 → addrm 0x0100 then 0x0102, rsp_data 0x7812, rsp_valid in cycle 3.
- Byte 0x00FF=0x80 → signed byte load rsp_data 0xFF80; unsigned byte load → 0x0080; single read at 0x00FE.
- Byte store 0xAB to 0x0101 with word 0x0100=0x1234 → one we pulse, addrm 0x0100, wmdata 0xAB34; subsequent word load returns 0xAB34.
- Word store 0xBEEF at 0xFFFF → two we pulses at addrm 0xFFFE then 0x0000; bytes 0xFFFF=EF and 0x0000=BE, neighbours unchanged; rsp_valid 5 cycles after acceptance.
- Assert reset_n=0 mid-cycle during W0 of a byte store → we falls immediately, memory unchanged, req_ready=1, rsp_valid=0; next request after release completes normally.
